// File: rtl/hilo_muldiv_if.sv
// HI/LO multiply/divide request/response bundle.
// master: execute stage (valid, op, a, b, flush); slave: the unit (busy, hi_new, lo_new, en).
interface hilo_muldiv_if;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi_new;
    logic [31:0] lo_new;
    logic        en;

    modport master (
        output valid, op, a, b, flush,
        input  busy, hi_new, lo_new, en
    );

    modport slave (
        input  valid, op, a, b, flush,
        output busy, hi_new, lo_new, en
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port.
// Ports: clk, reset (sync, active-low), bus (hilo_muldiv_if.slave).
module hilo_muldiv #(
    parameter int MULT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    hilo_muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state;
    state_t      next_state;
    logic [5:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        en_raw;
    logic        en_int;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [63:0] mul_res;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign accept = (state == IDLE) && bus.valid && !bus.flush;

    // Signed ops divide on magnitudes; signs come back in FIX.
    assign a_mag = (!bus.op[0] && bus.a[31]) ? -bus.a : bus.a;
    assign b_mag = (!bus.op[0] && bus.b[31]) ? -bus.b : bus.b;

    // Sign/zero extension to 64 bits makes one multiplier serve both ops.
    assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Product delay line; retiming spreads the multiplier across it.
    if (MULT_CYCLES == 1) begin : g_mul_comb
        assign mul_res = prod;
    end else begin : g_mul_pipe
        logic [63:0] pipe [MULT_CYCLES-1];
        always_ff @(posedge clk) begin
            pipe[0] <= prod;
            for (int k = 1; k < MULT_CYCLES - 1; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
        assign mul_res = pipe[MULT_CYCLES-2];
    end

    // One restoring step: shift in next dividend bit, try subtract.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};

    always_comb begin
        q_fix = quo;
        r_fix = rem;
        if (sgn_q && (a_q[31] ^ b_q[31])) begin
            q_fix = -quo;
        end
        if (sgn_q && a_q[31]) begin
            r_fix = -rem;
        end
        if (b_q == 32'd0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_q;
        end
    end

    always_comb begin
        res_hi = mul_res[63:32];
        res_lo = mul_res[31:0];
        if (state == FIX) begin
            res_hi = r_fix;
            res_lo = q_fix;
        end
    end

    always_comb begin
        next_state = state;
        en_raw     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = bus.op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                if (cnt == MUL_LAST) begin
                    en_raw     = 1'b1;
                    next_state = IDLE;
                end
            end
            DIV: begin
                if (cnt == DIV_LAST) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                en_raw     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (bus.flush) begin
            next_state = IDLE;
        end
    end

    // A flushed or reset cycle must never write HI/LO.
    assign en_int     = en_raw && !bus.flush && reset;
    assign bus.en     = en_int;
    assign bus.busy   = (state != IDLE);
    assign bus.hi_new = en_int ? res_hi : hi_q;
    assign bus.lo_new = en_int ? res_lo : lo_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sgn_q <= !bus.op[0];
                cnt   <= '0;
                dvs   <= b_mag;
                quo   <= a_mag;
                rem   <= '0;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
            end
            if (state == DIV) begin
                if (!diff[32]) begin
                    rem <= diff[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= shifted[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
            end
            if (en_int) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed spec cases plus random ops
// checked against an arithmetic reference model.
module tb_hilo_muldiv;

    localparam int MC = 2;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    hilo_muldiv_if bus ();

    hilo_muldiv #(.MULT_CYCLES(MC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint            sp;
        logic [63:0]       up;
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa  = a;
        sb_ = b;
        case (op)
            2'd0: begin
                sp = longint'(sa) * longint'(sb_);
                return sp;
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = sa / sb_;
                r = sa % sb_;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] op);
        return op[1] ? 33 : MC;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns in cycle 1.
    task automatic start(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push,
                         output int c0);
        exp_t        e;
        logic [63:0] m;
        bus.valid = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        c0        = cyc;
        if (push) begin
            m     = model(op, a, b);
            e.hi  = m[63:32];
            e.lo  = m[31:0];
            e.due = cyc + lat(op);
            sb.push_back(e);
        end
        step();
        bus.valid = 1'b0;
        chk("busy_cycle1", 64'(bus.busy), 64'd1);
    endtask

    // Counts busy cycles from cycle 1; returns in the cycle after en.
    task automatic wait_idle(input int l);
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            step();
        end
        chk("busy_len", 64'(n), 64'(l));
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        int c0;
        start(op, a, b, 1'b1, c0);
        wait_idle(lat(op));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_en cycle=%0d hi=%h lo=%h",
                         cyc, bus.hi_new, bus.lo_new);
            end else begin
                e = sb.pop_front();
                chk("result", {bus.hi_new, bus.lo_new}, {e.hi, e.lo});
                chk("en_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        int          c0;
        int          c1;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.valid = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        rst       = 1'b0;
        repeat (3) step();
        chk("reset_state",
            {30'd0, bus.busy, bus.en, bus.hi_new, bus.lo_new}, 96'd0);
        rst = 1'b1;
        step();

        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd0, 32'hFFFF_FFFD, 32'd5);

        start(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, c0);
        wait_idle(33);
        start(2'd3, 32'd100, 32'd7, 1'b1, c1);
        chk("b2b_accept", 64'(c1 - c0), 64'd34);
        wait_idle(33);

        run(2'd3, 32'h1234_5678, 32'd0);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd2, 32'hCAFE_0001, 32'd0);

        // Flush in cycle 10 of a divide, then a multiply right after.
        start(2'd2, 32'd1000, 32'd3, 1'b0, c0);
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        run(2'd1, 32'd3, 32'd4);

        // Flush on the write cycle suppresses en.
        start(2'd1, 32'd6, 32'd7, 1'b0, c0);
        repeat (MC - 1) step();
        bus.flush = 1'b1;
        #1;
        chk("flush_en", 64'(bus.en), 64'd0);
        step();
        bus.flush = 1'b0;
        chk("flush_en_busy", 64'(bus.busy), 64'd0);

        // Reset mid-divide with valid held.
        start(2'd2, 32'd77, 32'd5, 1'b0, c0);
        repeat (4) step();
        rst       = 1'b0;
        bus.valid = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        step();
        chk("mid_reset",
            {30'd0, bus.busy, bus.en, bus.hi_new, bus.lo_new}, 96'd0);
        rst       = 1'b1;
        bus.valid = 1'b0;
        step();
        chk("reset_no_accept", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run(op, a, b);
        end

        repeat (5) step();
        chk("queue_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
